// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter merging two register-file write requesters onto one write port.
// Grant is combinational (no grants under stall/reset); the winner's write is issued on RegWrite one cycle later.
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [1:0]        req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [1:0]        req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [1:0]        WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic [3:0]        pending,
  output logic [CNT_W-1:0]  wr_count
);

  typedef struct packed {
    logic [1:0]        rg;
    logic [DATA_W-1:0] dat;
  } wr_t;

  logic prio;
  logic open_slot;
  logic grant0;
  logic grant1;
  logic granted;
  wr_t  win;

  // prio names the requester that wins when both are valid.
  always_comb begin
    open_slot = !reset && !stall;
    grant0    = open_slot && req0_valid && (!req1_valid || !prio);
    grant1    = open_slot && req1_valid && (!req0_valid ||  prio);
    granted   = grant0 || grant1;
    win       = grant1 ? {req1_reg, req1_data} : {req0_reg, req0_data};
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio      <= 1'b0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      pending   <= '0;
      wr_count  <= '0;
    end else begin
      RegWrite <= granted;
      pending  <= granted ? (4'b0001 << win.rg) : 4'b0000;
      if (granted) begin
        WriteReg  <= win.rg;
        WriteData <= win.dat;
        prio      <= grant0;
      end
      if (RegWrite) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the write-data width.
REQ-002 Parameter CNT_W, default 8, SHALL set the issued-write counter width.
REQ-003 clk  in  1  sole clock; all state SHALL update on posedge clk only.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 stall  in  1  when high, no grants this cycle.
REQ-006 req0_valid  in  1  requester 0 has a write pending.
REQ-007 req0_reg  in  2  requester 0 target register number.
REQ-008 req0_data  in  DATA_W  requester 0 write data.
REQ-009 req0_ready  out  1  requester 0 granted this cycle (combinational).
REQ-010 req1_valid, req1_reg, req1_data, req1_ready SHALL mirror REQ-006..REQ-009 for requester 1.
REQ-011 WriteReg  out  2  register-file write address (registered).
REQ-012 WriteData  out  DATA_W  register-file write data (registered).
REQ-013 RegWrite  out  1  register-file write enable, one-cycle pulse per accepted write (registered).
REQ-014 pending  out  4  bit n high while an accepted write to register n has not yet been presented on RegWrite.
REQ-015 wr_count  out  CNT_W  number of writes issued since reset.

Function
REQ-016 Transfer on requester k SHALL occur in a cycle where reqk_valid=1 and reqk_ready=1.
REQ-017 reqk_ready SHALL be 0 whenever reset=1 or stall=1.
REQ-018 With stall=0 and exactly one requester valid, that requester SHALL be granted.
REQ-019 With stall=0 and both valid, the requester selected by a 1-bit priority pointer prio SHALL be granted; the other's ready SHALL be 0.
REQ-020 At most one ready SHALL be high in any cycle.
REQ-021 After any grant to requester k, prio SHALL become the other requester at the next edge; without a grant prio SHALL hold.
REQ-022 A requester holding valid=1 with stall=0 SHALL be granted within 2 cycles (no starvation).
REQ-023 Same-register requests from both requesters SHALL NOT be merged; they SHALL be serialised in grant order.
REQ-024 Latency: a transfer at edge N SHALL drive RegWrite=1, WriteReg=reqk_reg, WriteData=reqk_data during the cycle after edge N, exactly one cycle.
REQ-025 Without a transfer, RegWrite SHALL be 0 at the next edge; WriteReg and WriteData SHALL hold their last values.
REQ-026 pending bit n SHALL set at the transfer edge and clear at the following edge, when RegWrite issues; with back-to-back writes to n it SHALL stay high.
REQ-027 wr_count SHALL increment by 1 at each edge where RegWrite=1 is sampled, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 stall SHALL NOT cancel a write already accepted; its RegWrite pulse SHALL still occur.
REQ-029 Data or register changes on a requester while its ready=0 SHALL have no effect.

Reset
REQ-030 With reset=1 at a posedge, the following SHALL be cleared at that edge: RegWrite=0, WriteReg=0, WriteData=0, pending=0, wr_count=0, prio=0 (requester 0 first).
REQ-031 Reset SHALL override an in-flight write: an accepted write not yet issued SHALL be dropped, with no RegWrite pulse after reset.
REQ-032 Both ready outputs SHALL be 0 throughout reset.

Verification
REQ-033 Single request: reset, then req0 valid, reg=2, data=32'hAAAAAAAA for 1 cycle -> req0_ready=1, and next cycle RegWrite=1, WriteReg=2, WriteData=32'hAAAAAAAA, pending=4'b0100 for one cycle, then wr_count=1.
REQ-034 Contention: both valid for 4 cycles (req0 reg1 data 32'h11111111, req1 reg3 data 32'h33333333) -> grants alternate 0,1,0,1; RegWrite is high 4 consecutive cycles; wr_count=4.
REQ-035 Same register: both valid targeting reg0 with data 32'hA and 32'hB, prio=0 -> WriteData 32'hA then 32'hB on consecutive cycles, pending[0] high 2 cycles.
REQ-036 Stall: stall=1 for 3 cycles with both valid -> both ready=0, RegWrite=0; stall released -> grant goes to prio.
REQ-037 Reset mid-operation: accept a write at edge N, assert reset for edge N+1 -> RegWrite=0 and pending=0 after N+1, wr_count=0.
REQ-038 Wrap: CNT_W=2, issue 5 writes -> wr_count sequence 1,2,3,0,1.
